mio_vram_engine: RTL and testbench
==================================

# mio_vram_engine

Write-port arbiter and block-operation engine for the text-mode VRAM behind the VGA controller. It sits between the CPU's VRAM write path (address, data, write strobe from the MIO bus) and the VRAM, and shares the single write port with a hardware fill/copy engine. The engine accelerates screen clear and scroll for the keyboard console. CPU writes always have priority; the engine uses only idle write slots and a dedicated read port.

## Interface

Parameters:
- AW, 13, cell address width
- DW, 7, cell data width (ASCII)
- CELLS, 4800, number of text cells (80x60); all engine addresses wrap modulo CELLS

Ports:
- clk  in  1  system clock (sys_clk domain)
- clrn  in  1  asynchronous active-low reset
- cpu_we  in  1  CPU VRAM write strobe (wvram)
- cpu_addr  in  AW  CPU cell address
- cpu_data  in  DW  CPU cell data
- cmd_valid  in  1  engine command request
- cmd_ready  out  1  engine can accept a command (= not busy)
- cmd_op  in  1  0 = FILL, 1 = COPY
- cmd_dst  in  AW  first destination cell
- cmd_src  in  AW  first source cell (COPY only)
- cmd_len  in  AW  number of cells, 0..CELLS
- cmd_char  in  DW  fill character (FILL only)
- vram_we  out  1  registered VRAM write enable
- vram_waddr  out  AW  registered write address
- vram_wdata  out  DW  registered write data
- vram_raddr  out  AW  engine read address (synchronous RAM, data valid one cycle after sampling edge)
- vram_rdata  in  DW  read data
- busy  out  1  engine operation in progress
- done  out  1  one-cycle pulse when an operation completes

## Operation

- States: IDLE, FILL, RD, CAP, WR, FIN.
- IDLE: cmd_ready=1. On cmd_valid, latch op/dst/src/len/char into registers, set busy. len=0 -> FIN directly, no writes. Else FILL (op 0) or RD (op 1).
- Write-port arbitration, every cycle: if cpu_we=1 the CPU write is issued (vram_* <= cpu_addr/cpu_data, we=1); else if the engine has a pending write it is issued; else vram_we <= 0. The CPU is never stalled. Any engine write blocked by the CPU is retried unchanged the next cycle.
- FILL: each unblocked cycle issues write (dst, char); then dst <= dst+1 mod CELLS and remaining <= remaining-1. On the last write -> FIN.
- COPY (forward, one cell per iteration):
  - RD: drive vram_raddr = src.
  - CAP: capture vram_rdata into the hold register; attempt write (dst, rdata).
  - If the write is blocked -> WR. WR retries the write from the hold register until it is unblocked.
  - On a successful write, advance src/dst mod CELLS and decrement remaining. If remaining > 0 -> RD, else FIN.
- Overlap: correct only for src > dst, or for non-overlapping regions, which covers scroll-up. src < dst with overlap is unsupported and is not checked.
- FIN: done=1 for one cycle, busy=0 -> IDLE.
- cmd_valid while busy is ignored; commands are not queued.
- Address arithmetic: increment with compare; at CELLS-1 the next address is 0. cmd_dst/cmd_src >= CELLS is out of range: no check, wrap applies after the first increment.
- Asynchronous reset (clrn=0), including mid-operation: state IDLE; vram_we=0, vram_waddr=0, vram_wdata=0, vram_raddr=0, busy=0, done=0, cmd_ready=1 after release. Any operation in progress is aborted; cells already written stay written.

## Timing

- CPU write latency: cpu_we sampled at edge k -> vram_we=1 with the CPU address/data during cycle k+1 (after edge k).
- Command accepted at edge a. The first FILL write is driven at edge a+1 and visible after it, if there is no CPU conflict.
- Unobstructed FILL of N cells: writes visible in cycles a+2..a+N+1, done high in cycle a+N+2.
- Unobstructed COPY: 2 cycles per cell (RD, CAP).
- Each CPU write overlapping an engine write slot adds exactly one cycle.
- cmd_ready is combinational from state (IDLE); busy is registered.
- done is never asserted in the same cycle as cmd_ready=0 for a new command; done is asserted once per accepted command, including len=0.

## Test plan

- FILL dst=4720 len=80 char=0x20, no CPU traffic -> 80 consecutive writes to addresses 4720..4799 with data 0x20, then one done pulse; busy high for 81 cycles.
- FILL dst=4790 len=20 -> writes to 4790..4799 then 0..9; no write at address >= 4800.
- FILL len=100 with cpu_we asserted on every third cycle (addr 5, data 0x41) -> all CPU writes appear one cycle later unmodified; 100 engine writes all occur, each exactly once; completion delayed by the number of conflicting cycles.
- COPY src=80 dst=0 len=4720 over a preloaded RAM model, then FILL dst=4720 len=80 -> RAM model equals the original shifted up one row, with a blank last row.
- Command with len=0 -> no vram_we from the engine; done pulse 2 cycles after accept. cmd_valid asserted during a busy FILL -> ignored; the FILL result is unchanged.
- Assert clrn low mid-COPY -> all outputs 0 immediately; after release cmd_ready=1, and a new FILL runs correctly.

Source files
------------

// File: rtl/mio_vram_engine.sv
// VRAM write-port arbiter with a fill/copy block engine.
// The CPU always owns the write port when it writes; the engine fills the
// idle slots. Copies read one cell at a time through a synchronous read port.
module mio_vram_engine #(
   parameter int AW    = 13,
   parameter int DW    = 7,
   parameter int CELLS = 4800
) (
   input  logic          clk,
   input  logic          clrn,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_data,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_op,
   input  logic [AW-1:0] cmd_dst,
   input  logic [AW-1:0] cmd_src,
   input  logic [AW-1:0] cmd_len,
   input  logic [DW-1:0] cmd_char,
   output logic          vram_we,
   output logic [AW-1:0] vram_waddr,
   output logic [DW-1:0] vram_wdata,
   output logic [AW-1:0] vram_raddr,
   input  logic [DW-1:0] vram_rdata,
   output logic          busy,
   output logic          done
);

   typedef enum logic [2:0] {S_IDLE, S_FILL, S_RD, S_CAP, S_WR, S_FIN} state_t;

   localparam logic [AW-1:0] LAST = AW'(CELLS - 1);
   localparam logic [AW-1:0] ONE  = AW'(1);

   state_t        state_q, state_d;
   logic [AW-1:0] dst_q, dst_d;
   logic [AW-1:0] src_q, src_d;
   logic [AW-1:0] rem_q, rem_d;
   logic [DW-1:0] char_q, char_d;
   logic [DW-1:0] hold_q, hold_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          we_q, we_d;
   logic [AW-1:0] waddr_q, waddr_d;
   logic [DW-1:0] wdata_q, wdata_d;

   logic          eng_req;
   logic          eng_grant;
   logic [AW-1:0] eng_addr;
   logic [DW-1:0] eng_data;

   // Address increment that wraps at the end of the text screen.
   function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] a);
      return (a == LAST) ? '0 : a + ONE;
   endfunction

   // Engine write request for the current state; a blocked write is simply
   // re-requested with the same address/data in the following cycle.
   always_comb begin
      eng_req  = 1'b0;
      eng_addr = dst_q;
      eng_data = char_q;
      case (state_q)
         S_FILL: eng_req = 1'b1;
         S_CAP: begin
            eng_req  = 1'b1;
            eng_data = vram_rdata;
         end
         S_WR: begin
            eng_req  = 1'b1;
            eng_data = hold_q;
         end
         default: ;
      endcase
   end

   assign eng_grant = eng_req & ~cpu_we;

   // Write-port arbitration: CPU first, then engine, else idle.
   always_comb begin
      we_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      if (cpu_we) begin
         we_d    = 1'b1;
         waddr_d = cpu_addr;
         wdata_d = cpu_data;
      end else if (eng_req) begin
         we_d    = 1'b1;
         waddr_d = eng_addr;
         wdata_d = eng_data;
      end
   end

   // Engine sequencing: command capture, fill loop, read/capture/write copy loop.
   always_comb begin
      state_d = state_q;
      dst_d   = dst_q;
      src_d   = src_q;
      rem_d   = rem_q;
      char_d  = char_q;
      hold_d  = hold_q;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               dst_d  = cmd_dst;
               src_d  = cmd_src;
               rem_d  = cmd_len;
               char_d = cmd_char;
               if (cmd_len == '0)
                  state_d = S_FIN;
               else if (cmd_op)
                  state_d = S_RD;
               else
                  state_d = S_FILL;
            end
         end
         S_FILL: begin
            if (eng_grant) begin
               dst_d = wrap_inc(dst_q);
               rem_d = rem_q - ONE;
               if (rem_q == ONE)
                  state_d = S_FIN;
            end
         end
         S_RD: state_d = S_CAP;
         S_CAP, S_WR: begin
            // Read data is only valid in CAP, so keep a copy for retries.
            if (state_q == S_CAP)
               hold_d = vram_rdata;
            if (eng_grant) begin
               src_d   = wrap_inc(src_q);
               dst_d   = wrap_inc(dst_q);
               rem_d   = rem_q - ONE;
               state_d = (rem_q == ONE) ? S_FIN : S_RD;
            end else begin
               state_d = S_WR;
            end
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign busy_d = (state_d != S_IDLE);
   assign done_d = (state_q == S_FIN);

   // State and output registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q <= S_IDLE;
         dst_q   <= '0;
         src_q   <= '0;
         rem_q   <= '0;
         char_q  <= '0;
         hold_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         dst_q   <= dst_d;
         src_q   <= src_d;
         rem_q   <= rem_d;
         char_q  <= char_d;
         hold_q  <= hold_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
      end
   end

   assign cmd_ready  = (state_q == S_IDLE);
   assign busy       = busy_q;
   assign done       = done_q;
   assign vram_we    = we_q;
   assign vram_waddr = waddr_q;
   assign vram_wdata = wdata_q;
   assign vram_raddr = src_q;

endmodule

// File: tb/tb_mio_vram_engine.sv
// Directed bench for mio_vram_engine with a behavioural 80x60 VRAM.
module tb_mio_vram_engine;

   localparam int CELLS = 4800;
   localparam int MAXC  = 20000;

   logic        clk = 1'b0;
   logic        clrn = 1'b1;
   logic        cpu_we = 1'b0;
   logic [12:0] cpu_addr = '0;
   logic [6:0]  cpu_data = '0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_op = 1'b0;
   logic [12:0] cmd_dst = '0;
   logic [12:0] cmd_src = '0;
   logic [12:0] cmd_len = '0;
   logic [6:0]  cmd_char = '0;
   logic        vram_we;
   logic [12:0] vram_waddr;
   logic [6:0]  vram_wdata;
   logic [12:0] vram_raddr;
   logic [6:0]  vram_rdata = '0;
   logic        busy;
   logic        done;

   mio_vram_engine #(.AW(13), .DW(7), .CELLS(CELLS)) dut (
      .clk        (clk),
      .clrn       (clrn),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_data   (cpu_data),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_dst    (cmd_dst),
      .cmd_src    (cmd_src),
      .cmd_len    (cmd_len),
      .cmd_char   (cmd_char),
      .vram_we    (vram_we),
      .vram_waddr (vram_waddr),
      .vram_wdata (vram_wdata),
      .vram_raddr (vram_raddr),
      .vram_rdata (vram_rdata),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   // Behavioural VRAM: one write port, one synchronous read port.
   logic [6:0] ram [0:CELLS-1];
   logic       preload = 1'b0;
   int         oob = 0;

   function automatic logic [6:0] pat(input int i);
      return 7'((i * 7 + 3) % 128);
   endfunction

   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < CELLS; i++) ram[i] <= pat(i);
      end else if (vram_we) begin
         if (int'(vram_waddr) < CELLS) ram[vram_waddr] <= vram_wdata;
         else oob <= oob + 1;
      end
      vram_rdata <= (int'(vram_raddr) < CELLS) ? ram[vram_raddr] : 7'd0;
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Per-command observations
   int eng_addr_q[$];
   int eng_data_q[$];
   int busy_cnt, done_at, cpu_ok, cpu_bad, ready_bad;
   logic done_after, ready_after;

   function automatic int seq_bad(input int dst, input int ch);
      int bad = 0;
      foreach (eng_addr_q[i])
         if (eng_addr_q[i] != (dst + i) % CELLS || eng_data_q[i] != ch) bad++;
      return bad;
   endfunction

   // Issue one command and watch it to completion (entered #1 after an edge).
   task automatic run_cmd(input logic op, input int dst, input int src, input int len,
                          input int ch, input bit traffic, input bit inject);
      bit cpu_prev;
      cmd_op    = op;
      cmd_dst   = 13'(dst);
      cmd_src   = 13'(src);
      cmd_len   = 13'(len);
      cmd_char  = 7'(ch);
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      eng_addr_q.delete();
      eng_data_q.delete();
      busy_cnt = 0; done_at = -1; cpu_ok = 0; cpu_bad = 0; ready_bad = 0;
      cpu_prev = 1'b0;
      for (int j = 0; j < MAXC; j++) begin
         if (busy) busy_cnt++;
         if (busy && cmd_ready) ready_bad++;
         if (cpu_prev) begin
            if (vram_we === 1'b1 && vram_waddr == 13'd5 && vram_wdata == 7'h41) cpu_ok++;
            else cpu_bad++;
         end else if (vram_we === 1'b1) begin
            eng_addr_q.push_back(int'(vram_waddr));
            eng_data_q.push_back(int'(vram_wdata));
         end
         if (done === 1'b1) begin
            done_at = j;
            break;
         end
         cpu_prev = traffic && (j % 3 == 0);
         cpu_we   = cpu_prev;
         cpu_addr = 13'd5;
         cpu_data = 7'h41;
         if (inject) begin
            cmd_valid = (j == 10 || j == 11);
            if (j == 10) begin
               cmd_op = 1'b0; cmd_dst = 13'd0; cmd_len = 13'd3; cmd_char = 7'h5A;
            end
         end
         @(posedge clk); #1;
      end
      cpu_we = 1'b0;
      cmd_valid = 1'b0;
      check("completes", 32'(done_at >= 0), 1);
      @(posedge clk); #1;
      done_after  = done;
      ready_after = cmd_ready;
      $display("cmd op=%0d dst=%0d src=%0d len=%0d: %0d engine writes, %0d cpu writes, done at +%0d",
               op, dst, src, len, eng_addr_q.size(), cpu_ok, done_at);
   endtask

   initial begin
      int bad;
      // Reset
      #2 clrn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_we", vram_we, 0);
      check("rst_waddr", vram_waddr, 0);
      check("rst_wdata", vram_wdata, 0);
      check("rst_raddr", vram_raddr, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      clrn = 1'b1;
      @(posedge clk); #1;
      check("rst_ready", cmd_ready, 1);

      // CPU write latency
      cpu_we = 1'b1; cpu_addr = 13'd123; cpu_data = 7'h55;
      @(posedge clk); #1;
      cpu_we = 1'b0;
      check("cpu_we", vram_we, 1);
      check("cpu_addr", vram_waddr, 123);
      check("cpu_data", vram_wdata, 7'h55);
      @(posedge clk); #1;
      check("cpu_we_off", vram_we, 0);

      // Last row clear
      run_cmd(1'b0, 4720, 0, 80, 8'h20, 1'b0, 1'b0);
      check("fill80_count", eng_addr_q.size(), 80);
      check("fill80_seq", seq_bad(4720, 8'h20), 0);
      check("fill80_busy", busy_cnt, 81);
      check("fill80_done_at", done_at, 81);
      check("fill80_done_pulse", done_after, 0);
      check("fill80_ready_after", ready_after, 1);
      check("fill80_ready_busy", ready_bad, 0);

      // Wrap-around fill with an ignored command mid-way
      run_cmd(1'b0, 4790, 0, 20, 8'h2D, 1'b0, 1'b1);
      check("wrap_count", eng_addr_q.size(), 20);
      check("wrap_seq", seq_bad(4790, 8'h2D), 0);
      check("wrap_last_addr", eng_addr_q[19], 9);
      check("wrap_done_at", done_at, 21);
      check("wrap_done_pulse", done_after, 0);
      check("wrap_oob", oob, 0);

      // Fill with CPU writes every third cycle
      run_cmd(1'b0, 200, 0, 100, 8'h2E, 1'b1, 1'b0);
      check("traffic_eng_count", eng_addr_q.size(), 100);
      check("traffic_seq", seq_bad(200, 8'h2E), 0);
      check("traffic_cpu_ok", cpu_ok, 51);
      check("traffic_cpu_bad", cpu_bad, 0);
      check("traffic_done_at", done_at, 151);
      check("traffic_busy", busy_cnt, 151);

      // Zero-length command
      run_cmd(1'b0, 33, 0, 0, 8'h41, 1'b0, 1'b0);
      check("len0_writes", eng_addr_q.size(), 0);
      check("len0_done_at", done_at, 1);
      check("len0_busy", busy_cnt, 1);
      check("len0_done_pulse", done_after, 0);

      // Scroll up one row: copy then blank the last row
      preload = 1'b1;
      @(posedge clk); #1;
      preload = 1'b0;
      run_cmd(1'b1, 0, 80, 4720, 0, 1'b0, 1'b0);
      check("copy_count", eng_addr_q.size(), 4720);
      check("copy_done_at", done_at, 9441);
      run_cmd(1'b0, 4720, 0, 80, 8'h20, 1'b0, 1'b0);
      bad = 0;
      for (int i = 0; i < CELLS; i++) begin
         if (i < 4720) begin
            if (ram[i] !== pat(i + 80)) bad++;
         end else begin
            if (ram[i] !== 7'h20) bad++;
         end
      end
      check("scroll_ram", bad, 0);
      check("scroll_oob", oob, 0);

      // Reset in the middle of a copy
      cmd_op = 1'b1; cmd_dst = 13'd500; cmd_src = 13'd1000; cmd_len = 13'd50;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      repeat (7) @(posedge clk);
      #2 clrn = 1'b0;
      #1;
      check("mid_rst_we", vram_we, 0);
      check("mid_rst_waddr", vram_waddr, 0);
      check("mid_rst_wdata", vram_wdata, 0);
      check("mid_rst_raddr", vram_raddr, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      @(posedge clk); #1;
      clrn = 1'b1;
      @(posedge clk); #1;
      check("mid_rst_ready", cmd_ready, 1);
      run_cmd(1'b0, 10, 0, 5, 8'h33, 1'b0, 1'b0);
      check("post_rst_count", eng_addr_q.size(), 5);
      check("post_rst_seq", seq_bad(10, 8'h33), 0);
      check("post_rst_done_at", done_at, 6);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
